// File: rtl/matrix_multiply_seq.sv
// Sequential N x N unsigned matrix multiplier, C = A x B, built around one MAC unit.
//
// Operands are written one element at a time into the A/B register files. A start
// pulse then runs N^3 multiply-accumulate cycles: k advances fastest, then j, then i.
// After the last MAC the FSM sits in DONE, and C can be read by row/column index.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset; clears A, B, C and aborts a computation
//   load_en   element write strobe (accepted in IDLE/DONE only)
//   load_sel  target matrix: 0 = A, 1 = B
//   load_row  row index of the element being written
//   load_col  column index of the element being written
//   input_val element value
//   start     begin computation (sampled in IDLE/DONE only)
//   busy      high while computing
//   done      high while C is valid
//   rd_row    read row index into C
//   rd_col    read column index into C
//   result    C[rd_row][rd_col] when done, else 0
module matrix_multiply_seq #(
  parameter int unsigned N    = 2,
  parameter int unsigned DW   = 8,
  parameter int unsigned IW   = 2,
  parameter int unsigned ACCW = 2 * DW + 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            load_sel,
  input  logic [IW-1:0]   load_row,
  input  logic [IW-1:0]   load_col,
  input  logic [DW-1:0]   input_val,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [IW-1:0]   rd_row,
  input  logic [IW-1:0]   rd_col,
  output logic [ACCW-1:0] result
);

  // Internal index width sized to the array so indexing never over-selects.
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic [AW-1:0]   i_q, j_q, k_q;
  logic [ACCW-1:0] acc_q;

  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   b_q [N][N];
  logic [ACCW-1:0] c_q [N][N];

  logic            load_ok;
  logic            rd_ok;
  logic [AW-1:0]   ld_r, ld_c, rd_r, rd_c;
  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] acc_d;

  // Extra leading zero keeps the compare correct when N == 2**IW.
  assign load_ok = ({1'b0, load_row} < (IW + 1)'(N)) && ({1'b0, load_col} < (IW + 1)'(N));
  assign rd_ok   = ({1'b0, rd_row} < (IW + 1)'(N)) && ({1'b0, rd_col} < (IW + 1)'(N));
  assign ld_r    = load_row[AW-1:0];
  assign ld_c    = load_col[AW-1:0];
  assign rd_r    = rd_row[AW-1:0];
  assign rd_c    = rd_col[AW-1:0];

  // Single MAC datapath; k == 0 starts a fresh dot product.
  assign prod  = {{DW{1'b0}}, a_q[i_q][k_q]} * {{DW{1'b0}}, b_q[k_q][j_q]};
  assign acc_d = ((k_q == '0) ? '0 : acc_q) + {{(ACCW - 2 * DW){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
    end else begin
      // A/B are frozen while computing.
      if (load_en && load_ok && (state_q != StCompute)) begin
        if (load_sel) b_q[ld_r][ld_c] <= input_val;
        else          a_q[ld_r][ld_c] <= input_val;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StCompute;
            busy_q  <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
          end
        end

        StCompute: begin
          acc_q <= acc_d;
          if (k_q == LastIdx) begin
            c_q[i_q][j_q] <= acc_d;
            k_q           <= '0;
            if (j_q == LastIdx) begin
              j_q <= '0;
              if (i_q == LastIdx) begin
                i_q     <= '0;
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end

        StDone: begin
          if (start) begin
            state_q <= StCompute;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
          end else if (load_en) begin
            // Any load attempt, even out of range, invalidates the result.
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    result = '0;
    if (done_q && rd_ok) result = c_q[rd_r][rd_c];
  end

endmodule
